// File: rtl/vc_arbiter_pkg.sv
// Shared encodings, field positions and limits for the virtual-channel arbiter.
// Also holds the grant bundle type and the destination back-pressure helper.
package vc_arbiter_pkg;

    localparam int unsigned WORD_W   = 6;
    localparam int unsigned COUNT_W  = 3;
    localparam int unsigned UMBRAL_W = 2;
    localparam int unsigned STREAK_W = 3;

    localparam logic [2:0] ST_RESET  = 3'd0;
    localparam logic [2:0] ST_INIT   = 3'd1;
    localparam logic [2:0] ST_IDLE   = 3'd2;
    localparam logic [2:0] ST_ACTIVE = 3'd3;
    localparam logic [2:0] ST_ERROR  = 3'd4;

    localparam logic [COUNT_W-1:0]  FIFO_DEPTH   = 3'd4;
    localparam logic [STREAK_W-1:0] STREAK_LIMIT = 3'd4;

    localparam int unsigned VC_BIT      = 5;
    localparam int unsigned DEST_BIT    = 4;
    localparam int unsigned PAYLOAD_MSB = 3;
    localparam int unsigned PAYLOAD_LSB = 0;

    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        logic elig_vc0;
        logic elig_vc1;
        logic gnt_vc0;
        logic gnt_vc1;
    } grant_t;

    // Reserve slots shrink the usable depth; 3-bit wrap is intentional.
    function automatic logic dest_blocked(input logic [COUNT_W-1:0]  count,
                                          input logic [UMBRAL_W-1:0] umbral);
        logic [COUNT_W-1:0] limit;
        limit = FIFO_DEPTH - {1'b0, umbral};
        return count >= limit;
    endfunction

endpackage

// File: rtl/vc_arbiter_if.sv
// Bus bundle between the arbiter and its VC / destination FIFOs and status logic.
// The slave modport is the arbiter's view; master is the environment's view.
interface vc_arbiter_if;
    import vc_arbiter_pkg::*;

    logic                init;
    logic [UMBRAL_W-1:0] umbral_D0;
    logic [UMBRAL_W-1:0] umbral_D1;
    logic                vc0_empty;
    logic                vc1_empty;
    word_t               vc0_data;
    word_t               vc1_data;
    logic [COUNT_W-1:0]  d0_count;
    logic [COUNT_W-1:0]  d1_count;
    logic                pop_vc0;
    logic                pop_vc1;
    logic                push_d0;
    logic                push_d1;
    word_t               data_out;
    logic                active_out;
    logic                idle_out;
    logic                error_out;

    modport slave (
        input  init, umbral_D0, umbral_D1, vc0_empty, vc1_empty,
               vc0_data, vc1_data, d0_count, d1_count,
        output pop_vc0, pop_vc1, push_d0, push_d1, data_out,
               active_out, idle_out, error_out
    );

    modport master (
        output init, umbral_D0, umbral_D1, vc0_empty, vc1_empty,
               vc0_data, vc1_data, d0_count, d1_count,
        input  pop_vc0, pop_vc1, push_d0, push_d1, data_out,
               active_out, idle_out, error_out
    );

endinterface

// File: rtl/vc_arb_grant.sv
// Combinational eligibility and priority: VC0 first, VC1 forced once the
// VC0 streak reaches the limit while both channels are eligible.
module vc_arb_grant
    import vc_arbiter_pkg::*;
(
    input  logic                active,
    input  logic [STREAK_W-1:0] streak,
    input  logic                vc0_empty,
    input  logic                vc1_empty,
    input  word_t               vc0_data,
    input  word_t               vc1_data,
    input  logic [COUNT_W-1:0]  d0_count,
    input  logic [COUNT_W-1:0]  d1_count,
    input  logic [UMBRAL_W-1:0] umbral_d0,
    input  logic [UMBRAL_W-1:0] umbral_d1,
    output grant_t              grant
);

    logic blk_d0;
    logic blk_d1;
    logic dest_ok0;
    logic dest_ok1;
    logic elig0;
    logic elig1;

    always_comb begin
        blk_d0   = dest_blocked(d0_count, umbral_d0);
        blk_d1   = dest_blocked(d1_count, umbral_d1);
        dest_ok0 = vc0_data[DEST_BIT] ? !blk_d1 : !blk_d0;
        dest_ok1 = vc1_data[DEST_BIT] ? !blk_d1 : !blk_d0;
        elig0    = active && !vc0_empty && dest_ok0;
        elig1    = active && !vc1_empty && dest_ok1;

        grant          = '0;
        grant.elig_vc0 = elig0;
        grant.elig_vc1 = elig1;
        if (elig0 && elig1) begin
            if (streak >= STREAK_LIMIT) begin
                grant.gnt_vc1 = 1'b1;
            end else begin
                grant.gnt_vc0 = 1'b1;
            end
        end else begin
            grant.gnt_vc0 = elig0;
            grant.gnt_vc1 = elig1;
        end
    end

endmodule

// File: rtl/vc_arbiter.sv
// Two-VC to two-destination arbiter: control FSM, reserve-slot registers and
// anti-starvation streak counter; transfers are combinational in ACTIVE.
module vc_arbiter
    import vc_arbiter_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    vc_arbiter_if.slave  bus
);

    logic [2:0]          state;
    logic [2:0]          state_nxt;
    logic [STREAK_W-1:0] streak;
    logic [UMBRAL_W-1:0] umb_d0;
    logic [UMBRAL_W-1:0] umb_d1;

    grant_t grant;
    word_t  head;
    logic   xfer;
    logic   head_err;
    logic   count_err;
    logic   err_cond;

    vc_arb_grant u_grant (
        .active    (state == ST_ACTIVE),
        .streak    (streak),
        .vc0_empty (bus.vc0_empty),
        .vc1_empty (bus.vc1_empty),
        .vc0_data  (bus.vc0_data),
        .vc1_data  (bus.vc1_data),
        .d0_count  (bus.d0_count),
        .d1_count  (bus.d1_count),
        .umbral_d0 (umb_d0),
        .umbral_d1 (umb_d1),
        .grant     (grant)
    );

    // Only a present head word can be malformed; an empty FIFO's head is don't-care.
    always_comb begin
        head_err  = (!bus.vc0_empty && (bus.vc0_data[VC_BIT] != 1'b0)) ||
                    (!bus.vc1_empty && (bus.vc1_data[VC_BIT] != 1'b1));
        count_err = (bus.d0_count > FIFO_DEPTH) || (bus.d1_count > FIFO_DEPTH);
        err_cond  = ((state == ST_IDLE) || (state == ST_ACTIVE)) && (head_err || count_err);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RESET:  state_nxt = ST_INIT;
            ST_INIT:   if (!bus.init) state_nxt = ST_IDLE;
            ST_IDLE:   if (!bus.vc0_empty || !bus.vc1_empty) state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (bus.vc0_empty && bus.vc1_empty) state_nxt = ST_IDLE;
            ST_ERROR:  state_nxt = ST_ERROR;
            default:   state_nxt = ST_RESET;
        endcase
        if (state != ST_RESET) begin
            if (bus.init) begin
                state_nxt = ST_INIT;
            end else if (err_cond) begin
                state_nxt = ST_ERROR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_RESET;
            streak <= '0;
            umb_d0 <= '0;
            umb_d1 <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) begin
                umb_d0 <= bus.umbral_D0;
                umb_d1 <= bus.umbral_D1;
            end
            if (grant.gnt_vc1 || bus.vc1_empty) begin
                streak <= '0;
            end else if (grant.gnt_vc0 && grant.elig_vc1) begin
                streak <= streak + 3'd1;
            end
        end
    end

    always_comb begin
        xfer         = grant.gnt_vc0 || grant.gnt_vc1;
        head         = grant.gnt_vc1 ? bus.vc1_data : bus.vc0_data;
        bus.pop_vc0  = grant.gnt_vc0;
        bus.pop_vc1  = grant.gnt_vc1;
        bus.push_d0  = xfer && !head[DEST_BIT];
        bus.push_d1  = xfer &&  head[DEST_BIT];
        bus.data_out = xfer ? head : '0;
    end

    assign bus.active_out = (state == ST_ACTIVE);
    assign bus.idle_out   = (state == ST_IDLE);
    assign bus.error_out  = (state == ST_ERROR);

endmodule

// File: doc/vc_arbiter.md
VC_ARBITER -- requirements
Module: vc_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 init  in  1  configuration strobe; umbral inputs are captured while high.
REQ-005 umbral_D0, umbral_D1  in  2 each  reserve slots per destination FIFO; 0 means block only when full.
REQ-006 vc0_empty, vc1_empty  in  1 each  virtual-channel FIFO empty flags.
REQ-007 vc0_data, vc1_data  in  6 each  head word of each first-word-fall-through VC FIFO; [5]=VC, [4]=dest (0=D0, 1=D1), [3:0]=payload.
REQ-008 d0_count, d1_count  in  3 each  destination FIFO fill level, 0..4.
REQ-009 pop_vc0, pop_vc1  out  1 each  pop strobe to the VC FIFO.
REQ-010 push_d0, push_d1  out  1 each  push strobe to the destination FIFO.
REQ-011 data_out  out  6  the word being transferred; 0 when no push is asserted.
REQ-012 active_out, idle_out, error_out  out  1 each  one-hot status of the state machine.

Function
REQ-013 The state machine SHALL have five states: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4, held in a 3-bit register.
REQ-014 Transitions SHALL be as follows.
- RESET goes to INIT unconditionally on the next cycle.
- INIT goes to IDLE on the first cycle with init=0.
- IDLE goes to ACTIVE when either VC FIFO is non-empty.
- ACTIVE goes to IDLE when both VC FIFOs are empty.
- Any non-RESET state goes to INIT when init=1; init takes priority over ERROR entry.
REQ-015 In INIT, umbral_D0 and umbral_D1 SHALL be registered every cycle; the last values captured are used until the next INIT.
REQ-016 Destination N SHALL be blocked when dN_count >= 4 - umbral_DN. The comparison uses 3-bit unsigned arithmetic.
REQ-017 A VC SHALL be eligible when it is non-empty, its head dest bit selects an unblocked destination, and the state is ACTIVE.
REQ-018 At most one transfer SHALL occur per cycle.
- A transfer asserts pop_vcX, push_dY (Y = head[4]) and data_out = head, all combinationally in the same cycle.
- Latency from an eligible head to its push is 0 cycles.
REQ-019 Priority SHALL be VC0 over VC1, with an anti-starvation rule.
- A 3-bit streak counter increments on each VC0 grant made while VC1 is also eligible.
- When streak=4 and VC1 is eligible, VC1 wins; the streak then clears.
- The streak also clears on any VC1 grant or whenever VC1 is empty.
REQ-020 If only one VC is eligible, it SHALL be granted regardless of the streak.
REQ-021 A head word whose bit[5] does not match its source VC, or any dN_count > 4, SHALL force ERROR on the next cycle.
REQ-022 In ERROR, all pop and push outputs SHALL be 0 and error_out=1. ERROR is sticky until reset or init.
REQ-023 In RESET, INIT and IDLE, all pop and push outputs SHALL be 0 and data_out SHALL be 0.
REQ-024 Status outputs SHALL follow the state.
- active_out=1 only in ACTIVE.
- idle_out=1 only in IDLE.
- error_out=1 only in ERROR.
- All three are 0 in RESET and INIT.

Reset
REQ-025 With reset=1 at a clock edge, the following SHALL take effect:
- state goes to RESET;
- the streak counter goes to 0;
- the stored umbrales go to 0;
- all outputs go to 0 in the following cycle.
REQ-026 Reset asserted mid-transfer SHALL suppress all pop and push outputs from the next edge, and no partial state SHALL persist.

Structure
REQ-027 A shared package SHALL hold the state encodings, FIFO depth 4, the field positions (VC bit 5, dest bit 4, payload [3:0]) and the streak limit 4.
REQ-028 The block SHALL contain one sub-module, vc_arb_grant: a combinational eligibility and priority unit taking streak, empties, heads, counts and umbrales and returning the grant.
REQ-029 The state register, streak counter and umbral registers SHALL reside in vc_arbiter.

Verification
REQ-030 Reset then init pulse with umbral_D0=1, umbral_D1=0 -> state sequence RESET, INIT, IDLE; idle_out=1; all strobes 0.
REQ-031 VC0 head 0x1B, VC1 head 0x2D, counts 0, both non-empty -> pop_vc0=1, push_d1=1, data_out=0x1B in the first ACTIVE cycle.
REQ-032 Both VCs continuously eligible for 10 cycles -> grant pattern VC0 x4, VC1, VC0 x4, VC1.
REQ-033 umbral_D0=1, d0_count=3, VC0 head 0x0C (dest D0), VC1 head 0x33 (dest D1) -> VC1 granted; VC0 held until d0_count=2.
REQ-034 VC1 head 0x1A (bit5=0) -> error_out=1 next cycle, strobes 0 thereafter; an init pulse returns the block to INIT, then IDLE.
REQ-035 Reset asserted during continuous transfers -> strobes 0 from the next cycle, state RESET, streak 0.
